imm_extend_pipe: RTL and testbench
==================================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, immediate output width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAGWIDTH, default 32, width of the sideband tag (e.g. PC) carried alongside each instruction.
REQ-003 SHALL have one clock and a synchronous, active-high reset, using the ports below.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- valid_i  input  1  upstream item valid.
- ready_o  output  1  block can accept an item this cycle.
- ImmSrc_i  input  3  immediate format select.
- Instr_i  input  32  raw instruction word.
- Tag_i  input  TAGWIDTH  sideband tag.
- valid_o  output  1  output item valid.
- ready_i  input  1  downstream accepts the item.
- ImmExt_o  output  DATAWIDTH  extended immediate.
- Tag_o  output  TAGWIDTH  tag of the output item.
- Err_o  output  1  output item used an illegal format.

Function
REQ-004 SHALL accept an item when valid_i && ready_o, and retire the output item when valid_o && ready_i.
REQ-005 SHALL decode ImmSrc_i as follows, with sign extension to DATAWIDTH from Instr_i[31] unless stated otherwise:
- 000 I: Instr[31:20].
- 001 S: {Instr[31:25], Instr[11:7]}.
- 010 B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
- 011 U: {Instr[31:12], 12'b0}.
- 100 J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
- 101 SHAMT: zero-extended; Instr[24:20] when DATAWIDTH=32, Instr[25:20] when DATAWIDTH=64.
- 110 ZIMM: zero-extended Instr[19:15].
- 111: illegal (see REQ-013).
REQ-006 SHALL compute the immediate combinationally at the input and register it; latency is exactly 1 cycle from acceptance to valid_o.
REQ-007 SHALL hold ImmExt_o, Tag_o and Err_o stable while valid_o && !ready_i.
REQ-008 SHALL use a two-entry skid buffer (main register and skid register) with states EMPTY, ONE and FULL:
- EMPTY -> ONE on accept.
- ONE -> ONE on accept with retire, or no accept with no retire.
- ONE -> EMPTY on retire without accept.
- ONE -> FULL on accept without retire.
- FULL -> ONE on retire; the skid entry moves to main.
REQ-009 SHALL drive ready_o from a register, ready_o = (state != FULL), with no combinational path from ready_i to ready_o.
REQ-010 SHALL sustain one item per cycle while ready_i stays high, and SHALL preserve order with no loss or duplication.
REQ-011 SHALL drive ImmExt_o, Tag_o and Err_o to 0 whenever valid_o is 0.

Reset
REQ-012 SHALL force state EMPTY, valid_o=0, ready_o=1 and all data registers to 0 on rst_i; the effect is visible the cycle after rst_i is sampled high, in-flight items are discarded, and valid_i is ignored during the reset cycle.

Configuration
REQ-013 With IMM_ILLEGAL_DETECT_EN defined, SHALL, for format 111, produce ImmExt_o=0 and Err_o=1 for that item, registered alongside it.
REQ-014 Without IMM_ILLEGAL_DETECT_EN, SHALL produce ImmExt_o=0 for format 111, with Err_o tied to 0 and no error flag storage.

Structure
REQ-015 SHALL place the ImmSrc encoding enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM, IMM_ILL) in shared package imm_pkg.
REQ-016 SHALL implement the combinational decode of REQ-005 as sub-module imm_decode (DATAWIDTH parameter), instantiated once at the input.

Verification
REQ-017 Benches SHALL cover:
- I-type, 32-bit: Instr=0xFFF00093, ImmSrc=000, ready_i=1 -> next cycle valid_o=1, ImmExt_o=0xFFFFFFFF.
- B-type, 32-bit: Instr=0xFE000EE3, ImmSrc=010 -> ImmExt_o=0xFFFFFFFC.
- U-type: 0x123450B7 at 32-bit -> 0x12345000; 0x800000B7 at DATAWIDTH=64 -> 0xFFFFFFFF80000000.
- Backpressure: ready_i=0, push tags 1 and 2 -> ready_o=0 after the second accept; ready_i=1 -> tags 1 then 2 on consecutive cycles, then ready_o=1.
- Illegal format: ImmSrc=111 with the macro -> Err_o=1, ImmExt_o=0; without the macro -> Err_o=0.
- Reset in FULL: assert rst_i -> next cycle valid_o=0, ready_o=1, and no stale item appears afterwards.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline.
//   imm_src_e : ImmSrc encoding of the immediate format select.
//   pipe_st_e : occupancy state of the two-entry output buffer.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_ZIMM  = 3'b110,
    IMM_ILL   = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } pipe_st_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder.
// Ports:
//   imm_src  in  immediate format select
//   instr    in  32-bit instruction word
//   imm      out immediate, extended to DATAWIDTH (32 or 64)
//   illegal  out format select is the reserved encoding
module imm_decode
  import imm_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  imm_src_e               imm_src,
  input  logic [31:0]            instr,
  output logic [DATAWIDTH-1:0]   imm,
  output logic                   illegal
);

  logic signed [31:0] sx_val;
  logic        [31:0] zx_val;
  logic               use_sx;
  logic               unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    sx_val  = '0;
    zx_val  = '0;
    use_sx  = 1'b0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: begin
        use_sx = 1'b1;
        sx_val = {{20{instr[31]}}, instr[31:20]};
      end
      IMM_S: begin
        use_sx = 1'b1;
        sx_val = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      IMM_B: begin
        use_sx = 1'b1;
        sx_val = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      IMM_U: begin
        use_sx = 1'b1;
        sx_val = {instr[31:12], 12'h000};
      end
      IMM_J: begin
        use_sx = 1'b1;
        sx_val = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      // RV64 shift amounts carry one extra bit.
      IMM_SHAMT: zx_val = (DATAWIDTH == 64) ? {26'h0, instr[25:20]} : {27'h0, instr[24:20]};
      IMM_ZIMM:  zx_val = {27'h0, instr[19:15]};
      default:   illegal = 1'b1;
    endcase
    // The 32-bit intermediate is already sign-correct; widening a signed
    // value replicates bit 31 up to DATAWIDTH.
    if (use_sx) imm = DATAWIDTH'(sx_val);
    else        imm = DATAWIDTH'(zx_val);
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage with valid/ready handshake and a two-entry
// skid buffer so ready_o is a pure register.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i/ready_o       upstream handshake
//   ImmSrc_i, Instr_i     format select and instruction word
//   Tag_i                 sideband tag carried with the item
//   valid_o/ready_i       downstream handshake
//   ImmExt_o, Tag_o       extended immediate and tag (0 when not valid)
//   Err_o                 item used the illegal format
// Build option: IMM_ILLEGAL_DETECT_EN enables the stored error flag;
// otherwise Err_o is tied low.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int TAGWIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            ImmSrc_i,
  input  logic [31:0]           Instr_i,
  input  logic [TAGWIDTH-1:0]   Tag_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATAWIDTH-1:0]  ImmExt_o,
  output logic [TAGWIDTH-1:0]   Tag_o,
  output logic                  Err_o
);

  pipe_st_e             state, state_n;
  logic                 ready_q;
  logic                 vld_p0;
  logic                 accept, retire;
  logic                 ld_main_in, ld_main_skid, ld_skid;
  logic [DATAWIDTH-1:0] dec_imm;
  logic                 dec_ill;
  logic [DATAWIDTH-1:0] main_imm_p0, skid_imm_p0;
  logic [TAGWIDTH-1:0]  main_tag_p0, skid_tag_p0;

  imm_decode #(.DATAWIDTH(DATAWIDTH)) u_decode (
    .imm_src (imm_src_e'(ImmSrc_i)),
    .instr   (Instr_i),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign vld_p0  = (state != ST_EMPTY);
  assign accept  = valid_i && ready_q;
  assign retire  = vld_p0 && ready_i;

  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_n    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && retire) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid = 1'b1;
          state_n = ST_FULL;
        end else if (retire) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // ready_o is low here, so no accept can coincide.
        if (retire) begin
          ld_main_skid = 1'b1;
          state_n      = ST_ONE;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // Stage p0: main/skid registers and control state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_EMPTY;
      ready_q     <= 1'b1;
      main_imm_p0 <= '0;
      main_tag_p0 <= '0;
      skid_imm_p0 <= '0;
      skid_tag_p0 <= '0;
    end else begin
      state   <= state_n;
      // Registered look-ahead keeps ready_i out of the ready_o cone.
      ready_q <= (state_n != ST_FULL);
      if (ld_main_in) begin
        main_imm_p0 <= dec_imm;
        main_tag_p0 <= Tag_i;
      end else if (ld_main_skid) begin
        main_imm_p0 <= skid_imm_p0;
        main_tag_p0 <= skid_tag_p0;
      end
      if (ld_skid) begin
        skid_imm_p0 <= dec_imm;
        skid_tag_p0 <= Tag_i;
      end
    end
  end

`ifdef IMM_ILLEGAL_DETECT_EN
  logic main_err_p0, skid_err_p0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_err_p0 <= 1'b0;
      skid_err_p0 <= 1'b0;
    end else begin
      if (ld_main_in)        main_err_p0 <= dec_ill;
      else if (ld_main_skid) main_err_p0 <= skid_err_p0;
      if (ld_skid)           skid_err_p0 <= dec_ill;
    end
  end

  assign Err_o = vld_p0 & main_err_p0;
`else
  logic unused_illegal;
  assign unused_illegal = dec_ill;
  assign Err_o          = 1'b0;
`endif

  assign ready_o  = ready_q;
  assign valid_o  = vld_p0;
  assign ImmExt_o = vld_p0 ? main_imm_p0 : '0;
  assign Tag_o    = vld_p0 ? main_tag_p0 : '0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a 32-bit and a 64-bit instance
// share one stimulus stream and one reference queue of accepted items.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [2:0]  ImmSrc_i = 3'b000;
  logic [31:0] Instr_i = 32'h0;
  logic [31:0] Tag_i = 32'h0;

  logic        ready32, valid32, err32;
  logic [31:0] imm32, tag32;
  logic        ready64, valid64, err64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int tests = 0;
  int fails = 0;
  logic started = 1'b0;
  logic rand_rdy = 1'b0;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] ins;
    logic [31:0] tag;
  } item_t;
  item_t q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.DATAWIDTH(32), .TAGWIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready32),
    .ImmSrc_i(ImmSrc_i), .Instr_i(Instr_i), .Tag_i(Tag_i),
    .valid_o(valid32), .ready_i(ready_i), .ImmExt_o(imm32), .Tag_o(tag32), .Err_o(err32)
  );

  imm_extend_pipe #(.DATAWIDTH(64), .TAGWIDTH(32)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready64),
    .ImmSrc_i(ImmSrc_i), .Instr_i(Instr_i), .Tag_i(Tag_i),
    .valid_o(valid64), .ready_i(ready_i), .ImmExt_o(imm64), .Tag_o(tag64), .Err_o(err64)
  );

  // Reference immediate: take the field as the format describes it, give
  // it its natural signedness, and widen with ordinary integer arithmetic.
  function automatic logic [63:0] model_imm(input logic [2:0] s, input logic [31:0] ins, input int w);
    longint v;
    case (s)
      3'd0: v = longint'($signed(ins[31:20]));
      3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd3: v = longint'($signed({ins[31:12], 12'h000}));
      3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'd5: v = (w == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      3'd6: v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    if (w == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  function automatic logic model_err(input logic [2:0] s);
`ifdef IMM_ILLEGAL_DETECT_EN
    return (s == 3'd7);
`else
    return (s == 3'd7) && 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the reference queue; handshakes are
  // evaluated here because inputs are already settled for the next edge.
  always @(negedge clk) begin
    if (started) begin
      chk("ready32", 64'(ready32), 64'(q.size() != 2));
      chk("ready64", 64'(ready64), 64'(q.size() != 2));
      chk("valid32", 64'(valid32), 64'(q.size() != 0));
      chk("valid64", 64'(valid64), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("imm32", 64'(imm32), model_imm(q[0].src, q[0].ins, 32));
        chk("imm64", imm64, model_imm(q[0].src, q[0].ins, 64));
        chk("tag32", 64'(tag32), 64'(q[0].tag));
        chk("tag64", 64'(tag64), 64'(q[0].tag));
        chk("err32", 64'(err32), 64'(model_err(q[0].src)));
        chk("err64", 64'(err64), 64'(model_err(q[0].src)));
      end else begin
        chk("idle_imm32", 64'(imm32), 64'h0);
        chk("idle_imm64", imm64, 64'h0);
        chk("idle_tag32", 64'(tag32), 64'h0);
        chk("idle_err32", 64'(err32), 64'h0);
      end
    end
    if (rst_i) begin
      q.delete();
      started = 1'b1;
    end else if (started) begin
      if (q.size() != 0 && ready_i) void'(q.pop_front());
      if (valid_i && q.size() < 2 + (ready_i ? 0 : 0) && ready32) begin
        item_t it;
        it.src = ImmSrc_i;
        it.ins = Instr_i;
        it.tag = Tag_i;
        q.push_back(it);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic push(input logic [2:0] s, input logic [31:0] ins, input logic [31:0] t);
    logic acc;
    int n;
    valid_i  = 1'b1;
    ImmSrc_i = s;
    Instr_i  = ins;
    Tag_i    = t;
    n = 0;
    do begin
      acc = ready32;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got ready_o=0 expected accept within 200 cycles");
    end
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    time t0;
    int n;

    // Pin the reference model with hand-derived values.
    chk("model_I", model_imm(3'd0, 32'hFFF00093, 32), 64'h00000000FFFFFFFF);
    chk("model_B", model_imm(3'd2, 32'hFE000EE3, 32), 64'h00000000FFFFFFFC);
    chk("model_U32", model_imm(3'd3, 32'h123450B7, 32), 64'h0000000012345000);
    chk("model_U64", model_imm(3'd3, 32'h800000B7, 64), 64'hFFFFFFFF80000000);
    chk("model_J", model_imm(3'd4, 32'h8000006F, 32), 64'h00000000FFF00000);
    chk("model_SH64", model_imm(3'd5, 32'h03F00013, 64), 64'h000000000000003F);
    chk("model_SH32", model_imm(3'd5, 32'h03F00013, 32), 64'h000000000000001F);

    idle(2);
    rst_i = 1'b0;
    idle(1);
    chk("rst_valid", 64'(valid32), 64'h0);
    chk("rst_ready", 64'(ready32), 64'h1);

    ready_i = 1'b1;
    push(3'd0, 32'hFFF00093, 32'd10);
    chk("I_valid", 64'(valid32), 64'h1);
    chk("I_imm", 64'(imm32), 64'hFFFFFFFF);
    chk("I_tag", 64'(tag32), 64'd10);
    push(3'd2, 32'hFE000EE3, 32'd11);
    chk("B_imm", 64'(imm32), 64'hFFFFFFFC);
    push(3'd3, 32'h123450B7, 32'd12);
    chk("U32_imm", 64'(imm32), 64'h12345000);
    push(3'd3, 32'h800000B7, 32'd13);
    chk("U64_imm", imm64, 64'hFFFFFFFF80000000);
    idle(1);

    // Backpressure: two items fill the buffer, then drain in order.
    ready_i = 1'b0;
    push(3'd0, 32'h00100093, 32'd1);
    push(3'd0, 32'h00200093, 32'd2);
    chk("bp_ready_low", 64'(ready32), 64'h0);
    chk("bp_head_tag", 64'(tag32), 64'd1);
    ready_i = 1'b1;
    idle(1);
    chk("bp_second_tag", 64'(tag32), 64'd2);
    chk("bp_ready_high", 64'(ready32), 64'h1);
    idle(1);
    chk("bp_drained", 64'(valid32), 64'h0);

    // Reserved format.
    push(3'd7, 32'hFFFFFFFF, 32'd20);
    chk("ill_imm", 64'(imm32), 64'h0);
`ifdef IMM_ILLEGAL_DETECT_EN
    chk("ill_err", 64'(err32), 64'h1);
`else
    chk("ill_err", 64'(err32), 64'h0);
`endif
    idle(1);

    // Reset while holding two items.
    ready_i = 1'b0;
    push(3'd1, 32'hFE000FA3, 32'h55);
    push(3'd4, 32'h8000006F, 32'h66);
    chk("full_ready", 64'(ready32), 64'h0);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    chk("rstfull_valid", 64'(valid32), 64'h0);
    chk("rstfull_ready", 64'(ready32), 64'h1);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("no_stale", 64'(valid32), 64'h0);
    end

    // Throughput: back-to-back items, one per cycle.
    t0 = $time;
    for (int i = 0; i < 6; i++) push(3'(i), 32'h8765_4321 ^ (i * 32'h0101_0101), 32'(100 + i));
    chk("throughput", 64'(($time - t0) / 10), 64'd6);
    idle(2);

    // Random downstream stalls with directed formats.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) push(3'(i % 8), $urandom, 32'(200 + i));
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    ready_i = 1'b1;
    n = 0;
    while (valid32 && n < 50) begin
      idle(1);
      n++;
    end
    chk("drain_done", 64'(valid32), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
